// File: rtl/tx_scheduler.sv
// rtl/tx_scheduler.sv - round-robin scheduler feeding 6-byte channel frames to the UART
module tx_scheduler #(
  parameter int         CH_NO   = 4,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [CH_NO*32-1:0]   i_data,
  input  logic [CH_NO-1:0]      i_available,
  output logic [CH_NO-1:0]      o_read,
  output logic [7:0]            o_byte,
  output logic                  o_byte_valid,
  input  logic                  i_byte_ready,
  output logic                  o_busy,
  output logic [3:0]            o_grant,
  output logic [15:0]           o_frame_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  ptr;
  logic [31:0] word;
  logic [2:0]  idx;
  logic [15:0] frame_cnt;

  logic             any_req;
  logic             hit_hi;
  logic             hit_lo;
  logic [3:0]       grant_hi;
  logic [3:0]       grant_lo;
  logic [3:0]       grant_c;
  logic [3:0]       ptr_nx;
  logic [CH_NO-1:0] grant_onehot;
  logic [31:0]      sel_word;
  logic [7:0]       hdr;
  logic [7:0]       csum;
  logic [7:0]       next_byte;
  logic             xfer;

  assign any_req       = |i_available;
  assign xfer          = o_byte_valid & i_byte_ready;
  assign o_frame_count = frame_cnt;

  // Rotating priority: lowest requester at or above ptr, else lowest overall (wrap).
  always_comb begin
    hit_hi   = 1'b0;
    hit_lo   = 1'b0;
    grant_hi = 4'd0;
    grant_lo = 4'd0;
    for (int k = CH_NO - 1; k >= 0; k--) begin
      if (i_available[k]) begin
        hit_lo   = 1'b1;
        grant_lo = 4'(k);
        if (k >= int'(ptr)) begin
          hit_hi   = 1'b1;
          grant_hi = 4'(k);
        end
      end
    end
    grant_c = hit_hi ? grant_hi : grant_lo;
    ptr_nx  = (grant_c == 4'(CH_NO - 1)) ? 4'd0 : grant_c + 4'd1;
  end

  always_comb begin
    grant_onehot = '0;
    sel_word     = 32'd0;
    for (int k = 0; k < CH_NO; k++) begin
      grant_onehot[k] = (grant_c == 4'(k));
      if (o_grant == 4'(k)) sel_word = i_data[32*k +: 32];
    end
  end

  assign hdr  = {HDR_TAG, o_grant};
  assign csum = hdr ^ word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];

  // Byte that follows the one currently presented at index idx.
  always_comb begin
    next_byte = csum;
    case (idx)
      3'd0:    next_byte = word[31:24];
      3'd1:    next_byte = word[23:16];
      3'd2:    next_byte = word[15:8];
      3'd3:    next_byte = word[7:0];
      default: next_byte = csum;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = LATCH;
      LATCH:   state_nx = SEND;
      SEND:    if (xfer && idx == 3'd5) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_read       <= '0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_grant      <= 4'd0;
      frame_cnt    <= 16'd0;
      ptr          <= 4'd0;
      word         <= 32'd0;
      idx          <= 3'd0;
    end else begin
      o_read <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            o_grant <= grant_c;
            ptr     <= ptr_nx;
            o_read  <= grant_onehot;
            o_busy  <= 1'b1;
          end
        end
        LATCH: begin
          word         <= sel_word;
          idx          <= 3'd0;
          o_byte       <= hdr;
          o_byte_valid <= 1'b1;
        end
        SEND: begin
          if (xfer) begin
            if (idx == 3'd5) begin
              o_byte_valid <= 1'b0;
              o_busy       <= 1'b0;
              frame_cnt    <= frame_cnt + 16'd1;
            end else begin
              idx    <= idx + 3'd1;
              o_byte <= next_byte;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// tb/tb_tx_scheduler.sv - directed self-checking bench for tx_scheduler
module tb_tx_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] data;
  logic [3:0]   avail;
  logic [3:0]   rd;
  logic [7:0]   byte_o;
  logic         valid;
  logic         ready;
  logic         busy;
  logic [3:0]   grant;
  logic [15:0]  fcnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_scheduler #(.CH_NO(4), .HDR_TAG(4'hA)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_data(data),
    .i_available(avail),
    .o_read(rd),
    .o_byte(byte_o),
    .o_byte_valid(valid),
    .i_byte_ready(ready),
    .o_busy(busy),
    .o_grant(grant),
    .o_frame_count(fcnt)
  );

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic do_reset();
    rst   = 1'b1;
    avail = 4'b0;
    ready = 1'b1;
    data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic recv_frame(input bit hold, output logic [47:0] f, output int t0,
                            output bit rd_in_send, output bit ok);
    int n;
    int guard;
    n = 0; guard = 0; f = '0; t0 = -1; rd_in_send = 1'b0; ok = 1'b1;
    while (n < 6) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        ok = 1'b0;
        break;
      end
      if (rd != 4'b0 && valid) rd_in_send = 1'b1;
      if (rd != 4'b0 && !hold) avail = avail & ~rd;
      if (valid && ready) begin
        if (n == 0) t0 = cyc;
        f = {f[39:0], byte_o};
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; avail = 4'b0; ready = 1'b0; data = '0;
    @(negedge clk);
    checks++; if (rd !== 4'b0) begin failures++; $display("FAIL reset_read got=%h exp=0", rd); end
    checks++; if (byte_o !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", byte_o); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant !== 4'h0) begin failures++; $display("FAIL reset_grant got=%h exp=0", grant); end
    checks++; if (fcnt !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", fcnt); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({busy, valid, rd} !== 6'b0) begin failures++; $display("FAIL idle_quiet got=%b exp=0", {busy, valid, rd}); end
  endtask

  task automatic test_single();
    logic [7:0] e [6];
    do_reset();
    e[0] = 8'hA2; e[1] = 8'h12; e[2] = 8'h34; e[3] = 8'h56; e[4] = 8'h78;
    e[5] = 8'hA2 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78;
    data[95:64] = 32'h12345678;
    avail = 4'b0100;
    @(negedge clk);
    checks++; if (rd !== 4'b0100) begin failures++; $display("FAIL single_read got=%b exp=0100", rd); end
    checks++; if (grant !== 4'd2) begin failures++; $display("FAIL single_grant got=%0d exp=2", grant); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    avail = 4'b0;
    @(negedge clk);
    checks++; if (rd !== 4'b0) begin failures++; $display("FAIL single_read_off got=%b exp=0", rd); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (valid !== 1'b1 || byte_o !== e[i]) begin
        failures++; $display("FAIL single_byte%0d got=%b/%h exp=1/%h", i, valid, byte_o, e[i]);
      end
    end
    @(negedge clk);
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_end got=%b%b exp=00", valid, busy); end
    checks++; if (fcnt !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", fcnt); end
  endtask

  task automatic test_round_robin();
    logic [31:0] w [4];
    logic [47:0] fr;
    logic [7:0]  eh;
    logic [7:0]  ec;
    int          t0;
    int          prev;
    bit          rs;
    bit          ok;
    do_reset();
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
    data  = {w[3], w[2], w[1], w[0]};
    avail = 4'hF;
    prev  = 0;
    for (int f = 0; f < 8; f++) begin
      recv_frame(1'b1, fr, t0, rs, ok);
      if (f == 7) avail = 4'h0;
      eh = {4'hA, 4'(f % 4)};
      ec = eh ^ w[f % 4][31:24] ^ w[f % 4][23:16] ^ w[f % 4][15:8] ^ w[f % 4][7:0];
      checks++;
      if (!ok || fr !== {eh, w[f % 4], ec}) begin
        failures++; $display("FAIL rr_frame%0d got=%h exp=%h", f, fr, {eh, w[f % 4], ec});
      end
      if (f > 0) begin
        checks++;
        if (t0 - prev !== 8) begin failures++; $display("FAIL rr_period%0d got=%0d exp=8", f, t0 - prev); end
      end
      checks++; if (rs !== 1'b0) begin failures++; $display("FAIL rr_read_in_send%0d got=1 exp=0", f); end
      prev = t0;
    end
    @(negedge clk);
    checks++; if (fcnt !== 16'd8) begin failures++; $display("FAIL rr_count got=%0d exp=8", fcnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] e [4];
    do_reset();
    e[0] = 8'hFE; e[1] = 8'hF0; e[2] = 8'h0D;
    e[3] = 8'hA0 ^ 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D;
    data[31:0] = 32'hCAFEF00D;
    avail = 4'b0001;
    @(negedge clk);
    avail = 4'b0;
    @(negedge clk);
    checks++; if (byte_o !== 8'hA0) begin failures++; $display("FAIL bp_byte0 got=%h exp=A0", byte_o); end
    @(negedge clk);
    checks++; if (byte_o !== 8'hCA) begin failures++; $display("FAIL bp_byte1 got=%h exp=CA", byte_o); end
    @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || byte_o !== 8'hFE) begin
        failures++; $display("FAIL bp_stall%0d got=%b/%h exp=1/FE", i, valid, byte_o);
      end
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid !== 1'b1 || byte_o !== e[i]) begin
        failures++; $display("FAIL bp_resume%0d got=%b/%h exp=1/%h", i, valid, byte_o, e[i]);
      end
      @(negedge clk);
    end
    checks++; if (valid !== 1'b0 || fcnt !== 16'd1) begin failures++; $display("FAIL bp_end got=%b/%0d exp=0/1", valid, fcnt); end
  endtask

  task automatic test_mid_request();
    logic [39:0] got;
    logic [7:0]  ec;
    bit          rs;
    do_reset();
    data[63:32] = 32'h01020304;
    data[31:0]  = 32'hAABBCCDD;
    ec = 8'hA1 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04;
    avail = 4'b0010;
    @(negedge clk);
    checks++; if (rd !== 4'b0010) begin failures++; $display("FAIL mid_read1 got=%b exp=0010", rd); end
    avail = 4'b0;
    @(negedge clk);
    checks++; if (byte_o !== 8'hA1) begin failures++; $display("FAIL mid_hdr1 got=%h exp=A1", byte_o); end
    avail = 4'b0001;
    rs  = 1'b0;
    got = '0;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      if (rd !== 4'b0) rs = 1'b1;
      got = {got[31:0], byte_o};
    end
    checks++; if (got !== {32'h01020304, ec}) begin failures++; $display("FAIL mid_payload got=%h exp=%h", got, {32'h01020304, ec}); end
    checks++; if (rs !== 1'b0) begin failures++; $display("FAIL mid_read_in_send got=1 exp=0"); end
    @(negedge clk);
    checks++; if (rd !== 4'b0 || valid !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b/%b exp=0000/0", rd, valid); end
    @(negedge clk);
    checks++; if (rd !== 4'b0001 || grant !== 4'd0) begin failures++; $display("FAIL mid_read0 got=%b/%0d exp=0001/0", rd, grant); end
    avail = 4'b0;
    @(negedge clk);
    checks++; if (byte_o !== 8'hA0) begin failures++; $display("FAIL mid_hdr0 got=%h exp=A0", byte_o); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    data[95:64] = 32'hDEADBEEF;
    avail = 4'b0100;
    @(negedge clk);
    avail = 4'b0;
    repeat (4) @(negedge clk);
    checks++; if (byte_o !== 8'hBE) begin failures++; $display("FAIL rst_byte3 got=%h exp=BE", byte_o); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rd, byte_o, valid, busy, grant, fcnt} !== 35'b0) begin
      failures++; $display("FAIL rst_async got=%h exp=0", {rd, byte_o, valid, busy, grant, fcnt});
    end
    @(negedge clk);
    rst   = 1'b0;
    avail = 4'b1001;
    @(negedge clk);
    checks++; if (rd !== 4'b0001 || grant !== 4'd0) begin failures++; $display("FAIL rst_fresh got=%b/%0d exp=0001/0", rd, grant); end
    avail = 4'b1000;
    @(negedge clk);
    checks++; if (byte_o !== 8'hA0 || fcnt !== 16'd0) begin failures++; $display("FAIL rst_hdr got=%h/%0d exp=A0/0", byte_o, fcnt); end
  endtask

  task automatic test_wrap();
    logic [47:0] fr;
    int          t0;
    bit          rs;
    bit          ok;
    do_reset();
    dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    checks++; if (fcnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=FFFF", fcnt); end
    data[31:0] = 32'h00000001;
    avail = 4'b0001;
    recv_frame(1'b0, fr, t0, rs, ok);
    checks++; if (!ok || fr[47:40] !== 8'hA0) begin failures++; $display("FAIL wrap_frame got=%h exp=A0", fr[47:40]); end
    @(negedge clk);
    checks++; if (fcnt !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=0000", fcnt); end
  endtask

  initial begin
    rst = 1'b1; avail = 4'b0; ready = 1'b1; data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mid_request();
    test_mid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
